register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
Parametrised multi-read-port register file with a second writeback port and a per-register busy scoreboard, for the pipelined MIPS core. Port A takes single-cycle ALU/load writebacks. Port B takes writebacks from long-latency units (mult/div, HI/LO moves). Reservations mark destinations busy until port B returns, and the block raises stall when a source register is still pending. Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, index width; depth = 2**ADDR_W
N_READ, 2, number of combinational read ports
DBG_IDX, 2, register index mirrored on dbg_data

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
rd_addr  in  N_READ*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W]
rd_en  in  N_READ  port k source is used this cycle
rd_data  out  N_READ*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_busy  out  N_READ  busy bit of rd_addr[k]
stall  out  1  OR over k of (rd_en[k] & rd_busy[k])
wa_en  in  1  port A write enable
wa_idx  in  ADDR_W  port A index
wa_data  in  DATA_W  port A data
rsv_en  in  1  reserve destination (long-latency issue)
rsv_idx  in  ADDR_W  index to mark busy
wb_en  in  1  port B write enable; also clears busy
wb_idx  in  ADDR_W  port B index
wb_data  in  DATA_W  port B data
busy_count  out  ADDR_W+1  number of busy registers
err  out  1  sticky protocol-error flag
dbg_data  out  DATA_W  current value of register DBG_IDX

Behaviour:
- Reset (reset==0, asynchronous):
  - all registers 0, all busy bits 0, busy_count 0, err 0.
  - Combinational outputs follow: rd_data 0, rd_busy 0, stall 0, dbg_data 0.
- Reads are combinational, zero latency.
  - rd_addr==0 returns 0 and busy 0 regardless of stored state.
  - Without the optional feature, a read returns the pre-edge value; data written at an edge is visible the following cycle.
- Writes occur on the rising clock edge.
  - Index 0: all writes, reservations and writebacks are ignored; no err.
  - wa_en and wb_en to the same index in the same cycle: port B data wins; err set.
  - Port A write to an index whose busy bit is set (WAW with a pending long op): data written, busy unchanged, err set.
- Scoreboard, per index i != 0, next busy state:
  - rsv_en & rsv_idx==i & busy[i]: stays 1; err set (double reservation).
  - rsv_en & rsv_idx==i: 1.
  - wb_en & wb_idx==i: 0.
  - Otherwise: unchanged.
  - Reserve has priority over writeback when both hit the same index in one cycle: busy ends 1, data from wb still written, no err.
  - wb_en to a non-busy index: data written, err set.
- busy_count is a registered counter updated in the same edge as the busy bits.
  - +1 per new reservation, -1 per clearing writeback, net 0 when both occur on different indices.
  - Never exceeds 2**ADDR_W - 1.
- err is sticky from the edge after the offending cycle until reset.
- stall is combinational from rd_en/rd_addr and the current busy bits.
- Reset asserted mid-operation discards all pending reservations; a later wb for one of them sets err.

Optional Feature:
REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding.
  - rd_data[k] returns wb_data if wb_en and wb_idx==rd_addr[k]; else wa_data if wa_en and wa_idx match; else the stored value. Index 0 still reads 0.
  - rd_busy[k] is 0 when a wb to that index is presented in the same cycle, so stall deasserts one cycle earlier.
  - dbg_data is unaffected by forwarding.
- Undefined: no forwarding; reads see the stored array only.

Test Plan:
1. Reset low, release; write wa r5=0xDEADBEEF; read port0 r5 next cycle -> 0xDEADBEEF. Write r0=0x1234 -> reads 0, err 0.
2. rsv r8; next cycle rd_en[1]=1, rd_addr[1]=8 -> rd_busy[1]=1, stall=1, busy_count=1. wb r8=0x00000007 -> following cycle stall=0, busy_count=0, read returns 7.
3. Same cycle wa r3=0x11 and wb r3=0x22 -> r3=0x22, err=1 and err remains 1 for 10 cycles until reset.
4. rsv r9 and wb r9=0x55 in one cycle (r9 not previously busy) -> r9=0x55, busy[9]=1, busy_count=1, err=0.
5. Reserve r1..r31 on consecutive cycles -> busy_count=31. Assert reset mid-sequence -> busy_count=0 and all data 0 immediately, without a clock edge.
6. With REGFILE_BYPASS_EN: wa r4=0xA5A5A5A5 while reading r4 -> rd_data=0xA5A5A5A5 in the same cycle. Without the macro -> old value, new value the next cycle.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb: multi-read-port register file with a second (long-latency)
// writeback port and a per-register busy scoreboard. Register 0 reads as zero
// and ignores every write, reservation and writeback.
// Optional same-cycle forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_sb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int N_READ  = 2,
    parameter int DBG_IDX = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_READ*ADDR_W-1:0] rd_addr,
    input  logic [N_READ-1:0]        rd_en,
    output logic [N_READ*DATA_W-1:0] rd_data,
    output logic [N_READ-1:0]        rd_busy,
    output logic                     stall,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_idx,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_idx,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_idx,
    input  logic [DATA_W-1:0]        wb_data,
    output logic [ADDR_W:0]          busy_count,
    output logic                     err,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [ADDR_W:0]   busy_count_r;
    logic              err_r;

    logic [DEPTH-1:0]  busy_nxt_s;
    logic [ADDR_W:0]   cnt_nxt_s;
    logic              wa_hit_s;
    logic              wb_hit_s;
    logic              rsv_hit_s;
    logic              rsv_wb_same_s;
    logic              new_rsv_s;
    logic              clr_wb_s;
    logic              err_hit_s;

    // Look up one read port: returns {busy, data} for the given index.
    function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] idx);
        logic [DATA_W:0] res;
        if (idx == ZERO_IDX) begin
            res = {1'b0, {DATA_W{1'b0}}};
        end
`ifdef REGFILE_BYPASS_EN
        else if (wb_en && (wb_idx == idx)) begin
            // Returning writeback also retires the pending reservation.
            res = {1'b0, wb_data};
        end
        else if (wa_en && (wa_idx == idx)) begin
            res = {busy_r[idx], wa_data};
        end
`endif
        else begin
            res = {busy_r[idx], mem_r[idx]};
        end
        return res;
    endfunction

    // Writes/reservations aimed at register 0 are dropped before anything else sees them.
    assign wa_hit_s  = wa_en  && (wa_idx  != ZERO_IDX);
    assign wb_hit_s  = wb_en  && (wb_idx  != ZERO_IDX);
    assign rsv_hit_s = rsv_en && (rsv_idx != ZERO_IDX);
    assign rsv_wb_same_s = rsv_hit_s && wb_hit_s && (rsv_idx == wb_idx);

    // A reservation only counts when the slot was free; a writeback only
    // clears when the slot was busy and not re-reserved in the same cycle.
    assign new_rsv_s = rsv_hit_s && !busy_r[rsv_idx];
    assign clr_wb_s  = wb_hit_s && busy_r[wb_idx] && !rsv_wb_same_s;

    // Protocol violations: A/B collision, WAW over a pending long op,
    // double reservation, writeback with nothing outstanding.
    assign err_hit_s = (wa_hit_s && wb_hit_s && (wa_idx == wb_idx))
                     || (wa_hit_s && busy_r[wa_idx])
                     || (rsv_hit_s && busy_r[rsv_idx])
                     || (wb_hit_s && !busy_r[wb_idx] && !rsv_wb_same_s);

    assign cnt_nxt_s = busy_count_r
                     + {{ADDR_W{1'b0}}, new_rsv_s}
                     - {{ADDR_W{1'b0}}, clr_wb_s};

    // Next scoreboard state: reservation beats writeback on the same index.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 1; i < DEPTH; i++) begin
            busy_nxt_s[i] = (rsv_hit_s && (rsv_idx == ADDR_W'(i)))
                          || (busy_r[i] && !(wb_hit_s && (wb_idx == ADDR_W'(i))));
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Register array: port B data wins over port A on the same index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wa_hit_s && !(wb_hit_s && (wb_idx == wa_idx))) begin
                mem_r[wa_idx] <= wa_data;
            end
            if (wb_hit_s) begin
                mem_r[wb_idx] <= wb_data;
            end
        end
    end

    // Scoreboard bits, busy counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r       <= {DEPTH{1'b0}};
            busy_count_r <= {(ADDR_W+1){1'b0}};
            err_r        <= 1'b0;
        end else begin
            busy_r       <= busy_nxt_s;
            busy_count_r <= cnt_nxt_s;
            err_r        <= err_r | err_hit_s;
        end
    end

    // Combinational read ports.
    always_comb begin
        rd_data = {(N_READ*DATA_W){1'b0}};
        rd_busy = {N_READ{1'b0}};
        for (int k = 0; k < N_READ; k++) begin
            {rd_busy[k], rd_data[k*DATA_W +: DATA_W]} = read_port(rd_addr[k*ADDR_W +: ADDR_W]);
        end
    end

    assign stall      = |(rd_en & rd_busy);
    assign busy_count = busy_count_r;
    assign err        = err_r;
    assign dbg_data   = mem_r[DBG_IDX];

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run against a reference model.
module tb_register_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_READ = 2;
    localparam int DEPTH  = 32;

    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_en;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        stall;
    logic        wa_en;
    logic [4:0]  wa_idx;
    logic [31:0] wa_data;
    logic        rsv_en;
    logic [4:0]  rsv_idx;
    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic [5:0]  busy_count;
    logic        err;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_READ(N_READ), .DBG_IDX(2)) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall),
        .wa_en(wa_en), .wa_idx(wa_idx), .wa_data(wa_data),
        .rsv_en(rsv_en), .rsv_idx(rsv_idx),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
        .busy_count(busy_count), .err(err), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wa_en;  logic [4:0] wa_idx;  logic [31:0] wa_data;
        logic        rsv_en; logic [4:0] rsv_idx;
        logic        wb_en;  logic [4:0] wb_idx;  logic [31:0] wb_data;
        logic [1:0]  rd_en;  logic [4:0] a0;      logic [4:0]  a1;
        logic [31:0] e_d0;   logic [31:0] e_d1;   logic [1:0]  e_busy;
        logic        e_stall; logic [5:0] e_cnt;  logic        e_err;
    } vec_t;

    vec_t tbl [10];

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_busy;
    logic        m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wa_en = 1'b0; wa_idx = 5'd0; wa_data = 32'd0;
        rsv_en = 1'b0; rsv_idx = 5'd0;
        wb_en = 1'b0; wb_idx = 5'd0; wb_data = 32'd0;
        rd_en = 2'b00; rd_addr = 10'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        idle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        m_busy = 32'd0;
        m_err  = 1'b0;
    endtask

    // Apply the architectural rules to the model for the inputs of this cycle.
    task automatic model_step();
        logic        e;
        logic [31:0] nb;
        e = 1'b0;
        if (wa_en && wa_idx != 5'd0) begin
            if (m_busy[wa_idx]) e = 1'b1;
            if (wb_en && wb_idx == wa_idx) e = 1'b1;
        end
        if (rsv_en && rsv_idx != 5'd0 && m_busy[rsv_idx]) e = 1'b1;
        if (wb_en && wb_idx != 5'd0 && !m_busy[wb_idx] && !(rsv_en && rsv_idx == wb_idx)) e = 1'b1;
        nb = m_busy;
        if (wb_en && wb_idx != 5'd0) nb[wb_idx] = 1'b0;
        if (rsv_en && rsv_idx != 5'd0) nb[rsv_idx] = 1'b1;
        if (wa_en && wa_idx != 5'd0) m_mem[wa_idx] = wa_data;
        if (wb_en && wb_idx != 5'd0) m_mem[wb_idx] = wb_data;
        m_busy = nb;
        m_err  = m_err | e;
    endtask

    // Expected {busy, data} of one read port from the model.
    function automatic logic [32:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 33'd0;
`ifdef REGFILE_BYPASS_EN
        if (wb_en && wb_idx == a) return {1'b0, wb_data};
        if (wa_en && wa_idx == a) return {m_busy[a], wa_data};
`endif
        return {m_busy[a], m_mem[a]};
    endfunction

    initial begin
        logic [32:0] r0;
        logic [32:0] r1;

        // wa_en,idx,data  rsv_en,idx  wb_en,idx,data  rd_en,a0,a1  e_d0,e_d1,e_busy,e_stall,e_cnt,e_err
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 2'b00, 5'd6, 5'd0,
                   32'h0, 32'h0, 2'b00, 1'b0, 6'd0, 1'b0};
        tbl[1] = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0,
                   32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 6'd0, 1'b0};
        tbl[2] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0,
                   32'h0, 32'h0, 2'b00, 1'b0, 6'd0, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 2'b10, 5'd5, 5'd8,
                   32'hDEADBEEF, 32'h0, 2'b10, 1'b1, 6'd1, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd8, 32'h7, 2'b00, 5'd5, 5'd5,
                   32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0, 6'd1, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 2'b10, 5'd5, 5'd8,
                   32'hDEADBEEF, 32'h7, 2'b00, 1'b0, 6'd0, 1'b0};
        tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h55, 2'b00, 5'd5, 5'd8,
                   32'hDEADBEEF, 32'h7, 2'b00, 1'b0, 6'd0, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 2'b10, 5'd8, 5'd9,
                   32'h7, 32'h55, 2'b10, 1'b1, 6'd1, 1'b0};
        tbl[8] = '{1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 1'b1, 5'd3, 32'h22, 2'b00, 5'd9, 5'd8,
                   32'h55, 32'h7, 2'b01, 1'b0, 6'd1, 1'b0};
        tbl[9] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd9,
                   32'h22, 32'h55, 2'b10, 1'b0, 6'd1, 1'b1};

        // Reset state
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rd_en = 2'b11; rd_addr = {5'd3, 5'd5};
        #1;
        check("rst_cnt", busy_count, 6'd0);
        check("rst_err", err, 1'b0);
        check("rst_rd", rd_data, 64'd0);
        check("rst_busy", rd_busy, 2'b00);
        check("rst_stall", stall, 1'b0);
        check("rst_dbg", dbg_data, 32'd0);
        next_cycle();
        reset = 1'b1;
        idle();

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            wa_en = tbl[i].wa_en; wa_idx = tbl[i].wa_idx; wa_data = tbl[i].wa_data;
            rsv_en = tbl[i].rsv_en; rsv_idx = tbl[i].rsv_idx;
            wb_en = tbl[i].wb_en; wb_idx = tbl[i].wb_idx; wb_data = tbl[i].wb_data;
            rd_en = tbl[i].rd_en; rd_addr = {tbl[i].a1, tbl[i].a0};
            #1;
            check($sformatf("row%0d_d0", i), rd_data[31:0], tbl[i].e_d0);
            check($sformatf("row%0d_d1", i), rd_data[63:32], tbl[i].e_d1);
            check($sformatf("row%0d_busy", i), rd_busy, tbl[i].e_busy);
            check($sformatf("row%0d_stall", i), stall, tbl[i].e_stall);
            check($sformatf("row%0d_cnt", i), busy_count, tbl[i].e_cnt);
            check($sformatf("row%0d_err", i), err, tbl[i].e_err);
            next_cycle();
        end
        idle();

        // err stays set until reset
        for (int c = 0; c < 10; c++) begin
            #1;
            check("err_sticky", err, 1'b1);
            next_cycle();
        end

        // Fill the scoreboard r1..r31
        pulse_reset();
        for (int i = 1; i < 32; i++) begin
            rsv_en = 1'b1; rsv_idx = 5'(i);
            #1;
            check("fill_cnt", busy_count, 6'(i - 1));
            next_cycle();
        end
        idle();
        #1;
        check("fill_cnt_full", busy_count, 6'd31);
        check("fill_err", err, 1'b0);
        next_cycle();

        // Reset mid-sequence discards reservations and data immediately
        pulse_reset();
        wa_en = 1'b1; wa_idx = 5'd5; wa_data = 32'hCAFEF00D;
        next_cycle();
        idle();
        for (int i = 1; i < 12; i++) begin
            rsv_en = 1'b1; rsv_idx = 5'(i);
            next_cycle();
        end
        rsv_idx = 5'd12;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        #1;
        check("mid_cnt_pre", busy_count, 6'd11);
        check("mid_rd_pre", rd_data[31:0], 32'hCAFEF00D);
        check("mid_stall_pre", stall, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_cnt_rst", busy_count, 6'd0);
        check("mid_rd_rst", rd_data[31:0], 32'd0);
        check("mid_stall_rst", stall, 1'b0);
        next_cycle();
        idle();
        reset = 1'b1;
        wb_en = 1'b1; wb_idx = 5'd10; wb_data = 32'h1;
        next_cycle();
        idle();
        #1;
        check("stale_wb_err", err, 1'b1);
        check("stale_wb_cnt", busy_count, 6'd0);

        // Same-cycle write then read
        pulse_reset();
        wa_en = 1'b1; wa_idx = 5'd4; wa_data = 32'hA5A5A5A5;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd4};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same", rd_data[31:0], 32'hA5A5A5A5);
`else
        check("byp_same", rd_data[31:0], 32'h0);
`endif
        next_cycle();
        wa_en = 1'b0;
        #1;
        check("byp_next", rd_data[31:0], 32'hA5A5A5A5);
        idle();
        rsv_en = 1'b1; rsv_idx = 5'd12;
        next_cycle();
        idle();
        wb_en = 1'b1; wb_idx = 5'd12; wb_data = 32'h77;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd12};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_wb_data", rd_data[31:0], 32'h77);
        check("byp_wb_stall", stall, 1'b0);
`else
        check("byp_wb_data", rd_data[31:0], 32'h0);
        check("byp_wb_stall", stall, 1'b1);
`endif
        next_cycle();
        idle();

        // Randomized run against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 64 == 0) begin
                pulse_reset();
                model_reset();
            end
            wa_en   = ($urandom_range(0, 2) == 0);
            wa_idx  = 5'($urandom_range(0, 7));
            wa_data = $urandom;
            rsv_en  = ($urandom_range(0, 3) == 0);
            rsv_idx = 5'($urandom_range(0, 7));
            wb_en   = ($urandom_range(0, 3) == 0);
            wb_idx  = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            rd_en   = 2'($urandom_range(0, 3));
            rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1;
            r0 = model_read(rd_addr[4:0]);
            r1 = model_read(rd_addr[9:5]);
            check("rnd_d0", rd_data[31:0], r0[31:0]);
            check("rnd_d1", rd_data[63:32], r1[31:0]);
            check("rnd_busy", rd_busy, {r1[32], r0[32]});
            check("rnd_stall", stall, (rd_en[0] & r0[32]) | (rd_en[1] & r1[32]));
            check("rnd_cnt", busy_count, 6'($countones(m_busy)));
            check("rnd_err", err, m_err);
            check("rnd_dbg", dbg_data, m_mem[2]);
            model_step();
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
